// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (uart_tx_hub today, uart_recv
// later): the line-FSM state encoding, frame geometry constants and the
// baud divider computation.
//
// Contents:
//   uart_state_e    - IDLE / START / DATA / STOP line states
//   DATA_BITS       - payload bits per frame (8N1)
//   calc_baud_div() - clock cycles per bit, integer-truncated
//   cnt_width()     - counter width able to hold 0..n-1 (min 1 bit)
// ---------------------------------------------------------------------------
package uart_pkg;

  // Line states shared by transmitter and receiver so that debug views and
  // assertions read the same encoding on both sides.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Cycles per bit; truncation is intentional so the line runs slightly
  // fast rather than slow when the ratio is not exact.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Width of a counter that must hold values 0..n-1, never narrower than
  // one bit so degenerate parameterisations still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head read. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
//
// Parameters:
//   WIDTH - entry width in bits
//   DEPTH - number of entries (power of two, at least 2)
//
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset, empties the FIFO
//   push_i  - write wdata_i at this edge (ignored when full)
//   wdata_i - data to write
//   pop_i   - discard the head entry at this edge (ignored when empty)
//   rdata_o - current head entry, valid while empty_o is low
//   full_o  - no free entry
//   empty_o - no stored entry
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Same address with different wrap bits means the writer has lapped the
  // reader by exactly one full buffer.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer update. Both pointers move independently, so a push and a pop
  // in the same cycle leave the occupancy unchanged and keep order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage carries no reset: entries are only ever read after being
  // written, and the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx_hub.sv
// ---------------------------------------------------------------------------
// uart_tx_hub
// Collects bytes from N_CH independent sources into per-channel FIFOs and
// serialises them onto one 8N1 UART line. Between frames an arbiter picks
// the next channel using fixed priority or round-robin.
//
// Parameters:
//   N_CH       - number of byte sources (1..8)
//   FIFO_DEPTH - entries per channel FIFO (power of two, at least 2)
//   CLK_FREQ   - clock frequency in Hz
//   BAUD       - line rate in bit/s
//
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   ch_valid  - per-channel byte offered
//   ch_data   - channel i byte on bits [8i+7:8i]
//   ch_ready  - per-channel FIFO not full
//   ch_enable - channel may be granted the line
//   rr_mode   - 0 fixed priority (lowest index wins), 1 round-robin
//   uart_tx   - serial output, idle high
//   busy      - high while a frame is on the line
//   ovf       - sticky per-channel "offered while full" flag
// ---------------------------------------------------------------------------
module uart_tx_hub
  import uart_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic [8*N_CH-1:0] ch_data,
  output logic [N_CH-1:0]   ch_ready,
  input  logic [N_CH-1:0]   ch_enable,
  input  logic              rr_mode,
  output logic              uart_tx,
  output logic              busy,
  output logic [N_CH-1:0]   ovf
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int CW       = cnt_width(BAUD_DIV);
  localparam int GW       = cnt_width(N_CH);

  // FIFO side
  logic [N_CH-1:0] push;
  logic [N_CH-1:0] pop;
  logic [N_CH-1:0] full;
  logic [N_CH-1:0] empty;
  logic [N_CH-1:0] eligible;
  logic [7:0]      head [N_CH];

  // Arbiter
  logic          found;
  logic [GW-1:0] grant_idx;
  logic [GW-1:0] start_idx;

  // Serializer state
  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic          baud_done;
  logic          line;
  logic          tx_q;
  logic          busy_q;
  logic [N_CH-1:0] ovf_q;

  // Ready is purely the registered full flag; a pop this cycle only shows
  // up as ready on the following cycle.
  assign ch_ready = ~full;
  assign push     = ch_valid & ch_ready;
  assign eligible = ~empty & ch_enable;

  for (genvar i = 0; i < N_CH; i++) begin : g_fifo
    sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk),
      .rst_i  (rst),
      .push_i (push[i]),
      .wdata_i(ch_data[8*i +: 8]),
      .pop_i  (pop[i]),
      .rdata_o(head[i]),
      .full_o (full[i]),
      .empty_o(empty[i])
    );
  end

  // Arbiter: walk the channels starting at start_idx and take the first
  // eligible one. Fixed priority always starts at channel 0; round-robin
  // starts just after the previous winner, wrapping at N_CH. It is only
  // consulted in IDLE, so mode/enable changes mid-frame wait for the next
  // arbitration.
  always_comb begin
    int cand;
    cand      = 0;
    found     = 1'b0;
    grant_idx = '0;
    start_idx = '0;
    if (rr_mode) begin
      start_idx = (last_grant_q == GW'(N_CH - 1)) ? '0 : last_grant_q + GW'(1);
    end
    for (int off = 0; off < N_CH; off++) begin
      cand = (int'(start_idx) + off) % N_CH;
      if (!found && (|(eligible & (N_CH'(1) << cand)))) begin
        found     = 1'b1;
        grant_idx = GW'(cand);
      end
    end
  end

  assign baud_done = (baud_q == CW'(BAUD_DIV - 1));

  // Serializer next-state logic. The baud counter restarts from zero on
  // every state change so each state lasts exactly BAUD_DIV cycles; inside
  // DATA it simply wraps between bits while bit_q steps through the byte.
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    last_grant_d = last_grant_q;
    pop          = '0;
    line         = 1'b1;

    unique case (state_q)
      IDLE: begin
        line = 1'b1;
        if (found) begin
          state_d           = START;
          shift_d           = head[grant_idx];
          last_grant_d      = grant_idx;
          pop[grant_idx]    = 1'b1;
          baud_d            = '0;
          bit_d             = '0;
        end
      end

      START: begin
        line = 1'b0;
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      DATA: begin
        line = shift_q[bit_q];
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      STOP: begin
        line = 1'b1;
        if (baud_done) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // State and output registers. The line and busy are registered from the
  // current state, which places them one cycle behind the FSM: an accept at
  // edge k is granted at k+1 and the start bit appears at k+2. Reset drives
  // the line high at the very next edge, aborting any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      last_grant_q <= GW'(N_CH - 1);
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      last_grant_q <= last_grant_d;
      tx_q         <= line;
      busy_q       <= (state_q != IDLE);
      ovf_q        <= ovf_q | (ch_valid & ~ch_ready);
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_tx_hub.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_hub
// Scoreboard bench for uart_tx_hub with BAUD_DIV=4, N_CH=2, FIFO_DEPTH=4.
// Stimulus pushes the expected bytes (in hand-derived transmit order) into
// a queue; an independent monitor decodes frames off uart_tx and compares.
// ---------------------------------------------------------------------------
module tb_uart_tx_hub;

  logic        clk;
  logic        rst;
  logic [1:0]  ch_valid;
  logic [15:0] ch_data;
  logic [1:0]  ch_ready;
  logic [1:0]  ch_enable;
  logic        rr_mode;
  logic        uart_tx;
  logic        busy;
  logic [1:0]  ovf;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  sbQ [$];
  logic        monInFrame = 1'b0;
  logic        expectGap  = 1'b0;

  uart_tx_hub #(
    .N_CH      (2),
    .FIFO_DEPTH(4),
    .CLK_FREQ  (16),
    .BAUD      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .ch_enable(ch_enable),
    .rr_mode  (rr_mode),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one cycle of data; signals stay driven until the caller changes them.
  task automatic applyStimulus(input logic [1:0] v, input logic [15:0] d);
    @(negedge clk);
    ch_valid = v;
    ch_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst      = 1'b1;
    ch_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_tx", uart_tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_ready", ch_ready, 2'b11);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((sbQ.size() != 0 || busy || monInFrame) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drain_left", sbQ.size(), 0);
  endtask

  task automatic countBusy(input int cycles, output int hi);
    hi = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (busy) hi++;
    end
  endtask

  // Monitor: detects a start bit, samples each bit in its second cycle,
  // checks the stop bit and scores the byte. Reset aborts any frame.
  initial begin : monitor
    int         cyc;
    int         cycleNo;
    int         lastStart;
    logic       prevTx;
    logic [7:0] rxByte;
    logic [7:0] expByte;
    cyc = 0; cycleNo = 0; lastStart = -1; prevTx = 1'b1; rxByte = '0; expByte = '0;
    forever begin
      @(negedge clk);
      cycleNo++;
      if (rst) begin
        monInFrame = 1'b0;
        prevTx     = 1'b1;
        lastStart  = -1;
      end else begin
        if (!monInFrame) begin
          if (prevTx && !uart_tx) begin
            monInFrame = 1'b1;
            cyc        = 0;
            checkOutput("busy_at_start", busy, 1);
            if (expectGap && lastStart >= 0)
              checkOutput("frame_gap", cycleNo - lastStart, 41);
            lastStart = cycleNo;
          end
        end else begin
          cyc++;
          if (cyc == 2) begin
            checkOutput("start_bit", uart_tx, 0);
          end else if (cyc >= 5 && cyc <= 33 && (cyc % 4) == 1) begin
            rxByte = {uart_tx, rxByte[7:1]};
          end else if (cyc == 37) begin
            checkOutput("stop_bit", uart_tx, 1);
          end else if (cyc == 39) begin
            if (sbQ.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL unexpected_frame: got 0x%02h expected no frame", rxByte);
            end else begin
              expByte = sbQ.pop_front();
              checkOutput("frame_byte", rxByte, expByte);
            end
            monInFrame = 1'b0;
          end
        end
        prevTx = uart_tx;
      end
    end
  end

  initial begin : stimulus
    int  n;
    int  sent;
    int  guard;
    logic rdy;
    logic [7:0] b;
    rst       = 1'b1;
    ch_valid  = 2'b00;
    ch_data   = '0;
    ch_enable = 2'b11;
    rr_mode   = 1'b0;

    // Single byte: latency, bit pattern, busy width
    $display("[TB] single byte 0xA5");
    resetDut();
    sbQ.push_back(8'hA5);
    applyStimulus(2'b01, 16'h00A5);
    ch_valid = 2'b00;
    @(negedge clk); checkOutput("lat_k0_tx", uart_tx, 1);
    @(negedge clk); checkOutput("lat_k1_tx", uart_tx, 1);
    @(negedge clk); checkOutput("lat_k2_tx", uart_tx, 0);
    n = 1;
    guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      guard++;
      if (busy) n++;
      else break;
    end
    checkOutput("busy_width", n, 40);
    waitIdle();

    // Fixed priority
    $display("[TB] fixed priority");
    resetDut();
    rr_mode = 1'b0;
    sbQ.push_back(8'h11); sbQ.push_back(8'h22); sbQ.push_back(8'h33);
    applyStimulus(2'b11, 16'h3311);
    applyStimulus(2'b01, 16'h0022);
    ch_valid = 2'b00;
    waitIdle();

    // Round-robin
    $display("[TB] round robin");
    resetDut();
    rr_mode = 1'b1;
    sbQ.push_back(8'h11); sbQ.push_back(8'h33); sbQ.push_back(8'h22);
    applyStimulus(2'b11, 16'h3311);
    applyStimulus(2'b01, 16'h0022);
    ch_valid = 2'b00;
    waitIdle();

    // Disabled channel fills, overflows, then drains in order
    $display("[TB] disabled channel");
    resetDut();
    rr_mode   = 1'b0;
    ch_enable = 2'b01;
    sbQ.push_back(8'hC1); sbQ.push_back(8'hC2);
    sbQ.push_back(8'hC3); sbQ.push_back(8'hC4);
    applyStimulus(2'b10, 16'hC100);
    applyStimulus(2'b10, 16'hC200);
    applyStimulus(2'b10, 16'hC300);
    applyStimulus(2'b10, 16'hC400);
    checkOutput("full_ready", ch_ready, 2'b01);
    applyStimulus(2'b10, 16'hC500);
    ch_valid = 2'b00;
    checkOutput("ovf_set", ovf, 2'b10);
    countBusy(60, n);
    checkOutput("disabled_busy", n, 0);
    @(negedge clk);
    ch_enable = 2'b11;
    waitIdle();
    checkOutput("ovf_sticky", ovf, 2'b10);

    // Reset mid-frame
    $display("[TB] reset mid-frame");
    resetDut();
    applyStimulus(2'b01, 16'h005A);
    applyStimulus(2'b01, 16'h006B);
    ch_valid = 2'b00;
    guard = 0;
    while (uart_tx && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("abort_frame_started", uart_tx, 0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_tx", uart_tx, 1);
    checkOutput("abort_ready", ch_ready, 2'b11);
    checkOutput("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    countBusy(100, n);
    checkOutput("abort_no_frame", n, 0);
    waitIdle();

    // Continuous stream across pointer wrap
    $display("[TB] continuous stream");
    resetDut();
    expectGap = 1'b1;
    sent  = 0;
    guard = 0;
    while (sent < 20 && guard < 2000) begin
      b = 8'(37 * sent + 5);
      @(negedge clk);
      ch_valid = 2'b01;
      ch_data  = {8'h00, b};
      rdy      = ch_ready[0];
      @(posedge clk);
      if (rdy) begin
        sbQ.push_back(b);
        sent++;
      end
      guard++;
    end
    #1;
    ch_valid = 2'b00;
    checkOutput("stream_accepted", sent, 20);
    waitIdle();
    expectGap = 1'b0;
    checkOutput("stream_ovf", ovf, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_hub.md
UART_TX_HUB -- requirements
Module: uart_tx_hub

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, giving the number of byte-source channels (1..8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving per-channel FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have parameter CLK_FREQ, default 100_000_000, giving the clock frequency in Hz.
REQ-004 The block SHALL have parameter BAUD, default 9600, giving the line rate; BAUD_DIV = CLK_FREQ/BAUD, integer-truncated.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port ch_valid, input, N_CH bits: per-channel byte offered.
REQ-008 The block SHALL have port ch_data, input, 8*N_CH bits: channel i byte on bits [8i+7:8i].
REQ-009 The block SHALL have port ch_ready, output, N_CH bits: per-channel FIFO not full.
REQ-010 The block SHALL have port ch_enable, input, N_CH bits: channel eligible for arbitration (switch-driven).
REQ-011 The block SHALL have port rr_mode, input, 1 bit: 0 selects fixed priority, 1 selects round-robin.
REQ-012 The block SHALL have port uart_tx, output, 1 bit: serial line, 8N1, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-014 The block SHALL have port ovf, output, N_CH bits: sticky per-channel "valid while not ready" flag.

Function
REQ-015 A channel byte SHALL be accepted on a rising edge where ch_valid[i] and ch_ready[i] are both high, and written into FIFO i at that edge.
REQ-016 ch_ready[i] SHALL equal NOT full of FIFO i, with no bypass path, so a pop does not raise ready in the same cycle.
REQ-017 Transmit FSM states SHALL be IDLE, START, DATA and STOP.
REQ-018 In IDLE, if any FIFO that is non-empty and enabled exists, the FSM SHALL grant exactly one channel, pop its head byte, and enter START at the same edge.
REQ-019 With rr_mode=0, the lowest-index eligible channel SHALL win arbitration.
REQ-020 With rr_mode=1, the search SHALL start at (last_grant+1) mod N_CH, and last_grant SHALL update on each grant.
REQ-021 uart_tx SHALL be 0 for BAUD_DIV cycles in START.
REQ-022 DATA SHALL send 8 bits LSB first, each held for BAUD_DIV cycles, using a 3-bit bit counter.
REQ-023 STOP SHALL hold uart_tx at 1 for BAUD_DIV cycles, then return to IDLE.
REQ-024 Transmission SHALL be back-to-back: the next grant may occur on the IDLE cycle immediately after STOP, giving 1 idle-high cycle between frames.
REQ-025 Latency SHALL be 2 cycles: for an accept at edge k with an idle FSM and an empty hub, uart_tx SHALL fall at edge k+2.
REQ-026 The baud counter SHALL count 0..BAUD_DIV-1 and wrap, reloading at every state transition.
REQ-027 busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-028 A disabled channel SHALL keep accepting bytes up to full but never be granted, and its bytes SHALL be retained until it is re-enabled.
REQ-029 Changes to rr_mode and ch_enable during a frame SHALL not affect that frame and SHALL take effect at the next arbitration.
REQ-030 ovf[i] SHALL set on any cycle with ch_valid[i]=1 and ch_ready[i]=0, and clear only on reset.
REQ-031 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, with full and empty derived from the MSB comparison, and SHALL wrap without loss.
REQ-032 A simultaneous push and pop on the same FIFO SHALL keep the count unchanged and preserve data order.

Reset
REQ-033 On rst, at the next edge: uart_tx=1, busy=0, ovf=0, all FIFOs empty (ch_ready all 1), FSM=IDLE, last_grant=N_CH-1, counters=0.
REQ-034 A reset asserted mid-frame SHALL abort the frame, and uart_tx SHALL be 1 from the next edge.

Structure
REQ-035 The FSM state encodings and the BAUD_DIV computation SHALL live in shared package uart_pkg, reused by uart_recv.
REQ-036 The FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated N_CH times via generate.
REQ-037 The arbiter and serializer SHALL be in uart_tx_hub itself, with no extra sub-module.

Verification (CLK_FREQ=16, BAUD=4, BAUD_DIV=4, frame 40 cycles, N_CH=2, FIFO_DEPTH=4)
REQ-038 Single byte 0xA5 on ch0 accepted at edge k -> uart_tx: start low at k+2, then bits 1,0,1,0,0,1,0,1, then stop high, each 4 cycles; busy high for 40 cycles.
REQ-039 Fixed priority: ch0 queues 0x11,0x22 and ch1 queues 0x33 in the same cycle -> frames are sent in order 0x11, 0x22, 0x33.
REQ-040 Round-robin with the same stimulus -> frames are sent in order 0x11, 0x33, 0x22.
REQ-041 ch1 is offered 5 bytes with ch_enable[1]=0 -> ch_ready[1] is 0 after 4 bytes and ovf[1]=1; after enable, 4 frames are sent in order.
REQ-042 rst pulsed at cycle 15 of a frame -> uart_tx=1 and ch_ready=2'b11 from the next edge, and no further frame is sent.
REQ-043 Continuous valid on ch0 for 20 bytes -> gaps between frames are exactly 1 cycle, with no byte loss or reorder across pointer wrap.
